// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing control for a 5-stage MIPS pipeline.
// Shadows EX/MEM/WB control state to drive stalls, flushes and forwarding.
module pipe_hazard_ctrl #(
    parameter int CNT_W  = 16,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_regw,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_memr,
    input  logic              id_branch,
    input  logic              id_jump,
    input  logic              ex_taken,
    input  logic              mem_busy,
    output logic              stall_pc,
    output logic              bubble_ex,
    output logic              flush_ifid,
    output logic              freeze,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic              valid;
        logic              regw;
        logic [REG_AW-1:0] dst;
        logic              memr;
        logic              branch;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              use_rs;
        logic              use_rt;
    } ex_rec_t;

    typedef struct packed {
        logic              valid;
        logic              regw;
        logic [REG_AW-1:0] dst;
    } wr_rec_t;

    typedef enum logic [2:0] {
        M_NONE,
        M_BUSY,
        M_TAKEN,
        M_LOAD,
        M_JUMP
    } mode_e;

    ex_rec_t          ex_q, ex_d;
    wr_rec_t          mem_q, mem_d;
    wr_rec_t          wb_q, wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic  haz_t;
    logic  haz_l;
    logic  haz_j;
    logic  ld_hit;
    mode_e mode;

    assign haz_t  = ex_q.valid & ex_q.branch & ex_taken;
    assign ld_hit = (id_use_rs && (id_rs == ex_q.dst)) ||
                    (id_use_rt && (id_rt == ex_q.dst));
    assign haz_l  = id_valid & ex_q.valid & ex_q.memr & ex_q.regw &
                    (ex_q.dst != '0) & ld_hit;
    assign haz_j  = id_valid & id_jump;

    // One case wins per cycle; reset masks every control output.
    always_comb begin
        mode = M_NONE;
        if (rst)           mode = M_NONE;
        else if (mem_busy) mode = M_BUSY;
        else if (haz_t)    mode = M_TAKEN;
        else if (haz_l)    mode = M_LOAD;
        else if (haz_j)    mode = M_JUMP;
    end

    always_comb begin
        stall_pc   = 1'b0;
        bubble_ex  = 1'b0;
        flush_ifid = 1'b0;
        freeze     = 1'b0;
        unique case (mode)
            M_BUSY: begin
                freeze   = 1'b1;
                stall_pc = 1'b1;
            end
            M_TAKEN: begin
                flush_ifid = 1'b1;
                bubble_ex  = 1'b1;
            end
            M_LOAD: begin
                stall_pc  = 1'b1;
                bubble_ex = 1'b1;
            end
            M_JUMP: begin
                flush_ifid = 1'b1;
            end
            default: ;
        endcase
    end

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic              used,
        input logic              ex_v,
        input wr_rec_t           m,
        input wr_rec_t           w
    );
        fwd_sel = 2'b00;
        if (ex_v && used && (src != '0)) begin
            if (m.valid && m.regw && (m.dst == src))
                fwd_sel = 2'b01;
            else if (w.valid && w.regw && (w.dst == src))
                fwd_sel = 2'b10;
        end
    endfunction

    assign fwd_a = rst ? 2'b00 :
        fwd_sel(ex_q.rs, ex_q.use_rs, ex_q.valid, mem_q, wb_q);
    assign fwd_b = rst ? 2'b00 :
        fwd_sel(ex_q.rt, ex_q.use_rt, ex_q.valid, mem_q, wb_q);

    always_comb begin
        ex_d        = ex_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!mem_busy) begin
            wb_d        = mem_q;
            mem_d.valid = ex_q.valid;
            mem_d.regw  = ex_q.regw;
            mem_d.dst   = ex_q.dst;
            ex_d.valid  = id_valid & ~bubble_ex;
            ex_d.regw   = id_regw;
            ex_d.dst    = id_dst;
            ex_d.memr   = id_memr;
            ex_d.branch = id_branch;
            ex_d.rs     = id_rs;
            ex_d.rt     = id_rt;
            ex_d.use_rs = id_use_rs;
            ex_d.use_rt = id_use_rt;
        end
        if ((mode == M_LOAD) && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (((mode == M_TAKEN) || (mode == M_JUMP)) && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic
// checked against an instruction-queue model of the pipeline.
module tb_pipe_hazard_ctrl;

    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_use_rs, id_use_rt, id_regw;
    logic          id_memr, id_branch, id_jump, ex_taken, mem_busy;
    logic [4:0]    id_rs, id_rt, id_dst;
    logic          stall_pc, bubble_ex, flush_ifid, freeze;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(CW), .REG_AW(5)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_regw(id_regw), .id_dst(id_dst), .id_memr(id_memr),
        .id_branch(id_branch), .id_jump(id_jump),
        .ex_taken(ex_taken), .mem_busy(mem_busy),
        .stall_pc(stall_pc), .bubble_ex(bubble_ex),
        .flush_ifid(flush_ifid), .freeze(freeze),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Model: in-flight instructions; index 0=EX, 1=MEM, 2=WB.
    typedef struct {
        bit v, regw, memr, br, urs, urt;
        int dst, rs, rt;
    } ins_t;

    ins_t pipe[3];
    int   scnt = 0;
    int   fcnt = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic ins_t cur_id();
        ins_t i;
        i.v = id_valid; i.regw = id_regw; i.memr = id_memr;
        i.br = id_branch; i.urs = id_use_rs; i.urt = id_use_rt;
        i.dst = int'(id_dst); i.rs = int'(id_rs); i.rt = int'(id_rt);
        return i;
    endfunction

    function automatic bit reads(ins_t c, int r);
        return c.v && r != 0 &&
               ((c.urs && c.rs == r) || (c.urt && c.rt == r));
    endfunction

    // Distance to the youngest producer of r: 1 = MEM, 2 = WB.
    function automatic int fsel(int r, bit u);
        if (!pipe[0].v || !u || r == 0) return 0;
        for (int k = 1; k <= 2; k++)
            if (pipe[k].v && pipe[k].regw && pipe[k].dst == r) return k;
        return 0;
    endfunction

    task automatic tick();
        ins_t id;
        int   mode;
        id   = cur_id();
        mode = 0;
        @(negedge clk);
        if (!rst) begin
            if (mem_busy) mode = 1;
            else if (pipe[0].v && pipe[0].br && ex_taken) mode = 2;
            else if (pipe[0].v && pipe[0].memr && pipe[0].regw &&
                     reads(id, pipe[0].dst)) mode = 3;
            else if (id.v && id_jump) mode = 4;
        end
        check("stall_pc", stall_pc, (mode == 1 || mode == 3));
        check("bubble_ex", bubble_ex, (mode == 2 || mode == 3));
        check("flush_ifid", flush_ifid, (mode == 2 || mode == 4));
        check("freeze", freeze, (mode == 1));
        check("fwd_a", fwd_a, rst ? 0 : fsel(pipe[0].rs, pipe[0].urs));
        check("fwd_b", fwd_b, rst ? 0 : fsel(pipe[0].rt, pipe[0].urt));
        check("stall_cnt", stall_cnt, scnt);
        check("flush_cnt", flush_cnt, fcnt);
        @(posedge clk);
        if (rst) begin
            foreach (pipe[k]) pipe[k].v = 0;
            scnt = 0;
            fcnt = 0;
        end else if (mode != 1) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = id;
            if (mode == 2 || mode == 3) pipe[0].v = 0;
            if (mode == 3 && scnt < CMAX) scnt++;
            if ((mode == 2 || mode == 4) && fcnt < CMAX) fcnt++;
        end
        #1;
    endtask

    task automatic set_id(input bit v, regw, memr, input int dst,
                          input int rs, input bit urs,
                          input int rt, input bit urt);
        id_valid = v; id_regw = regw; id_memr = memr;
        id_dst = 5'(dst); id_rs = 5'(rs); id_use_rs = urs;
        id_rt = 5'(rt); id_use_rt = urt;
        id_branch = 0; id_jump = 0;
    endtask

    task automatic clr_all();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        ex_taken = 0;
        mem_busy = 0;
    endtask

    int s0, f0;

    initial begin
        foreach (pipe[k]) pipe[k] = '{default: 0};
        clr_all();
        rst = 1;
        @(posedge clk);
        #1;
        tick();
        rst = 0;
        check("rst_scnt", stall_cnt, 0);
        check("rst_fcnt", flush_cnt, 0);

        // lw $2 then add $3,$2,$4
        set_id(1, 1, 1, 2, 0, 0, 0, 0);
        tick();
        set_id(1, 1, 0, 3, 2, 1, 4, 0);
        #1;
        check("lu_stall", stall_pc, 1);
        check("lu_bubble", bubble_ex, 1);
        tick();
        check("lu_cnt", stall_cnt, 1);
        check("lu_once", stall_pc, 0);
        tick();
        check("lu_fwd_wb", fwd_a, 2'b10);

        // two writers of $5, then a reader of rs=rt=5
        set_id(1, 1, 0, 5, 0, 0, 0, 0);
        tick();
        tick();
        set_id(1, 1, 0, 6, 5, 1, 5, 1);
        tick();
        check("alu_fwd_a", fwd_a, 2'b01);
        check("alu_fwd_b", fwd_b, 2'b01);

        // $0 is never forwarded nor stalled on
        set_id(1, 1, 0, 0, 0, 0, 0, 0);
        tick();
        set_id(1, 0, 0, 0, 0, 1, 0, 0);
        tick();
        check("z_fwd", fwd_a, 2'b00);
        set_id(1, 1, 1, 0, 0, 0, 0, 0);
        tick();
        set_id(1, 1, 0, 3, 0, 1, 0, 0);
        #1;
        check("z_stall", stall_pc, 0);
        tick();

        // taken branch wins over a simultaneous load-use
        set_id(1, 1, 1, 2, 0, 0, 0, 0);
        id_branch = 1;
        tick();
        set_id(1, 1, 0, 3, 2, 1, 0, 0);
        ex_taken = 1;
        #1;
        check("tk_flush", flush_ifid, 1);
        check("tk_bubble", bubble_ex, 1);
        check("tk_stall", stall_pc, 0);
        s0 = scnt;
        f0 = fcnt;
        tick();
        ex_taken = 0;
        check("tk_fcnt", flush_cnt, f0 + 1);
        check("tk_scnt", stall_cnt, s0);

        // memory busy over a pending load-use
        set_id(1, 1, 1, 7, 0, 0, 0, 0);
        tick();
        set_id(1, 1, 0, 8, 7, 1, 0, 0);
        mem_busy = 1;
        s0 = scnt;
        repeat (3) begin
            #1;
            check("bz_freeze", freeze, 1);
            check("bz_stall", stall_pc, 1);
            check("bz_bubble", bubble_ex, 0);
            tick();
        end
        check("bz_cnt", stall_cnt, s0);
        mem_busy = 0;
        #1;
        check("bz_lu", bubble_ex, 1);
        tick();
        check("bz_cnt2", stall_cnt, s0 + 1);

        // stall counter saturation
        repeat (CMAX + 10) begin
            set_id(1, 1, 1, 1, 0, 0, 0, 0);
            tick();
            set_id(1, 0, 0, 0, 1, 1, 0, 0);
            tick();
        end
        check("sat", stall_cnt, CMAX);
        set_id(1, 1, 1, 1, 0, 0, 0, 0);
        tick();
        set_id(1, 0, 0, 0, 1, 1, 0, 0);
        tick();
        check("sat_hold", stall_cnt, CMAX);

        // reset in the middle of a load-use stall
        set_id(1, 1, 1, 1, 0, 0, 0, 0);
        tick();
        set_id(1, 0, 0, 0, 1, 1, 0, 0);
        rst = 1;
        #1;
        check("rs_stall", stall_pc, 0);
        check("rs_bubble", bubble_ex, 0);
        tick();
        rst = 0;
        #1;
        check("rs_after", stall_pc, 0);
        check("rs_cnt", stall_cnt, 0);
        tick();

        repeat (2000) begin
            rst       = ($urandom_range(0, 99) == 0);
            id_valid  = ($urandom_range(0, 9) < 8);
            id_regw   = $urandom_range(0, 1);
            id_memr   = ($urandom_range(0, 9) < 3);
            id_branch = ($urandom_range(0, 9) < 2);
            id_jump   = ($urandom_range(0, 9) == 0);
            id_use_rs = $urandom_range(0, 1);
            id_use_rt = $urandom_range(0, 1);
            id_rs     = 5'($urandom_range(0, 3));
            id_rt     = 5'($urandom_range(0, 3));
            id_dst    = 5'($urandom_range(0, 3));
            ex_taken  = $urandom_range(0, 1);
            mem_busy  = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
